// File: rtl/program_loader.sv
// rtl/program_loader.sv - encodes R-type fields into RISC-V words and writes them to instruction memory
// One accepted field set produces one write strobe on the following cycle at the next sequential address.
module program_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_STEP  = 4,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  finish,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [2:0]            func3,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [6:0]            func7,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic [CW-1:0]         word_count,
  output logic [CW-1:0]         add_count,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP_A = ADDR_WIDTH'(ADDR_STEP);

  state_t      state;
  logic        accept;
  logic        is_add;
  logic [31:0] word;

  assign in_ready = (state == LOAD) && (word_count < CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign word     = {func7, rs2, rs1, func3, rd, opcode};
  assign is_add   = (opcode == 7'b0110011) && (func3 == 3'd0) && (func7 == 7'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      word_count       <= '0;
      add_count        <= '0;
      done             <= 1'b0;
    end else begin
      mem_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            word_count <= '0;
            add_count  <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            mem_write_enable <= 1'b1;
            mem_write_data   <= word;
            // Address uses the pre-increment count, so the first word lands on BASE_ADDR.
            mem_address      <= BASE_A + ADDR_WIDTH'(word_count) * STEP_A;
            word_count       <= word_count + CW'(1);
            if (is_add) add_count <= add_count + CW'(1);
          end
          if (finish || (accept && word_count == CW'(DEPTH - 1))) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state      <= LOAD;
            done       <= 1'b0;
            word_count <= '0;
            add_count  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader
module tb_program_loader;

  logic        clock;
  logic        reset;
  logic        start;
  logic        finish;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  func3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  func7;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [4:0]  word_count;
  logic [4:0]  add_count;
  logic        done;

  int checks = 0;
  int errors = 0;
  int exp_idx = 0;
  int writes_seen = 0;
  int writes_pushed = 0;
  logic [63:0] sb[$];

  program_loader dut (
    .clock(clock), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .func3(func3), .rs1(rs1), .rs2(rs2), .func7(func7),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .word_count(word_count),
    .add_count(add_count), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clock);
      if (mem_write_enable === 1'b1) begin
        writes_seen++;
        if (sb.size() == 0) begin
          check("unexpected_write", {mem_address, mem_write_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [63:0] e;
          e = sb.pop_front();
          check("write_addr", {32'd0, mem_address}, {32'd0, e[63:32]});
          check("write_data", {32'd0, mem_write_data}, {32'd0, e[31:0]});
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    exp_idx = 0;
  endtask

  task automatic pulse_finish();
    @(posedge clock); #1 finish = 1'b1;
    @(posedge clock); #1 finish = 1'b0;
  endtask

  // Present one field set and wait for it to be accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic [6:0] op, input logic [4:0] d, input logic [2:0] f3,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] f7,
                      input logic [31:0] exp_data, input logic fin);
    int n;
    opcode = op; rd = d; func3 = f3; rs1 = s1; rs2 = s2; func7 = f7;
    in_valid = 1'b1;
    finish = fin;
    n = 0;
    @(negedge clock);
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (in_ready !== 1'b1) begin
      check("send_timeout", 64'd0, 64'd1);
    end else begin
      sb.push_back({32'(exp_idx * 4), exp_data});
      writes_pushed++;
      exp_idx++;
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    finish = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    opcode = '0; rd = '0; func3 = '0; rs1 = '0; rs2 = '0; func7 = '0;

    // 1: reset asserted between edges clears outputs asynchronously
    #2 reset = 1'b1;
    #1;
    check("rst_we", {63'd0, mem_write_enable}, 64'd0);
    check("rst_addr", {32'd0, mem_address}, 64'd0);
    check("rst_data", {32'd0, mem_write_data}, 64'd0);
    check("rst_counts", {54'd0, word_count, add_count}, 64'd0);
    check("rst_done_ready", {62'd0, done, in_ready}, 64'd0);
    @(posedge clock); #1;
    @(negedge clock) reset = 1'b0;
    repeat (2) @(negedge clock);
    check("idle_ready", {63'd0, in_ready}, 64'd0);

    // 2: ADD
    pulse_start();
    send(7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h002081B3, 1'b0);
    check("add_wc", {59'd0, word_count}, 64'd1);
    check("add_ac", {59'd0, add_count}, 64'd1);

    // 3: SUB leaves add_count unchanged
    send(7'b0110011, 5'd3, 3'd0, 5'd1, 5'd2, 7'b0100000, 32'h402081B3, 1'b0);
    check("sub_wc", {59'd0, word_count}, 64'd2);
    check("sub_ac", {59'd0, add_count}, 64'd1);

    // start while loading is ignored
    pulse_start();
    exp_idx = 2;
    check("start_ignored_wc", {59'd0, word_count}, 64'd2);
    pulse_finish();
    check("finish_done", {63'd0, done}, 64'd1);

    // 4: fill all 16 slots back to back
    pulse_start();
    check("restart_done", {63'd0, done}, 64'd0);
    check("restart_wc", {59'd0, word_count}, 64'd0);
    for (int i = 0; i < 16; i++) begin
      logic [4:0] r;
      r = 5'(i);
      send(7'b0110011, r, 3'd0, 5'd1, 5'd2, 7'd0, {7'd0, 5'd2, 5'd1, 3'd0, r, 7'b0110011}, 1'b0);
    end
    check("full_ready", {63'd0, in_ready}, 64'd0);
    check("full_done", {63'd0, done}, 64'd1);
    check("full_wc", {59'd0, word_count}, 64'd16);
    check("full_ac", {59'd0, add_count}, 64'd16);

    // 5: finish together with the 4th word
    pulse_start();
    send(7'b0010011, 5'd5, 3'd0, 5'd5, 5'd1, 7'd0, 32'h00128293, 1'b0);
    send(7'b0110011, 5'd6, 3'd7, 5'd4, 5'd3, 7'd0, 32'h00327333, 1'b0);
    send(7'b0110011, 5'd7, 3'd0, 5'd0, 5'd0, 7'd0, 32'h000003B3, 1'b0);
    send(7'b1111111, 5'd31, 3'd7, 5'd31, 5'd31, 7'b1111111, 32'hFFFFFFFF, 1'b1);
    check("fin_wc", {59'd0, word_count}, 64'd4);
    check("fin_ac", {59'd0, add_count}, 64'd1);
    check("fin_done", {63'd0, done}, 64'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("fin_no_accept", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    check("fin_wc_held", {59'd0, word_count}, 64'd4);

    // 6: reset during LOAD drops the pending write
    pulse_start();
    send(7'b0110011, 5'd1, 3'd0, 5'd2, 5'd3, 7'd0, 32'h003100B3, 1'b0);
    send(7'b0110011, 5'd2, 3'd0, 5'd2, 5'd3, 7'd0, 32'h00310133, 1'b0);
    check("pre_rst_we", {63'd0, mem_write_enable}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_we", {63'd0, mem_write_enable}, 64'd0);
    check("mid_rst_counts", {54'd0, word_count, add_count}, 64'd0);
    check("dropped_pending", 64'(sb.size()), 64'd1);
    sb.delete();
    writes_pushed--;
    @(negedge clock) reset = 1'b0;
    pulse_start();
    send(7'b0110011, 5'd9, 3'd0, 5'd8, 5'd7, 7'd0, 32'h007404B3, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("write_total", 64'(writes_seen), 64'(writes_pushed));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
